// File: rtl/serial_adder_unit.sv
// Button-driven digit-serial adder: LoadB/Run presses load operands from SW, then
// BPC bits are added per clock and the registered Sum/CO are updated once per add.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | waiting for presses; LoadB loads B, Run loads A and starts an add
// S_COMPUTE | adding one BPC-bit digit per clock, LSB digit first
// S_DONE    | result presented; waits for Run to be released before re-arming
module serial_adder_unit #(
    parameter int WIDTH = 16,
    parameter int BPC   = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             LoadB,
    input  logic             Run,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] Sum,
    output logic             CO,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             Busy,
    output logic             Done
);

    localparam int NDIG = WIDTH / BPC;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic loadb_meta_q, loadb_sync_q, loadb_prev_q;
    logic run_meta_q, run_sync_q, run_prev_q;
    logic loadb_press, run_press;

    logic [WIDTH-1:0] aval_q, bval_q, a_work_q, b_work_q, sum_sr_q, sum_q;
    logic             co_q, carry_q;
    logic [CW-1:0]    cnt_q;

    logic [BPC:0]     digit;
    logic [WIDTH-1:0] dig_ext, sum_next;
    logic             last_dig;

    // Synchronisers idle at 1 (button released) so reset never looks like a press.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            loadb_meta_q <= 1'b1;
            loadb_sync_q <= 1'b1;
            loadb_prev_q <= 1'b1;
            run_meta_q   <= 1'b1;
            run_sync_q   <= 1'b1;
            run_prev_q   <= 1'b1;
        end else begin
            loadb_meta_q <= LoadB;
            loadb_sync_q <= loadb_meta_q;
            loadb_prev_q <= loadb_sync_q;
            run_meta_q   <= Run;
            run_sync_q   <= run_meta_q;
            run_prev_q   <= run_sync_q;
        end
    end

    assign loadb_press = loadb_prev_q & ~loadb_sync_q;
    assign run_press   = run_prev_q & ~run_sync_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (run_press)  state_d = S_COMPUTE;
            S_COMPUTE: if (last_dig)   state_d = S_DONE;
            S_DONE:    if (run_sync_q) state_d = S_IDLE;
            default:                   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        Busy = (state_q == S_COMPUTE);
        Done = (state_q == S_DONE);
    end

    always_comb begin
        digit    = {1'b0, a_work_q[BPC-1:0]} + {1'b0, b_work_q[BPC-1:0]}
                 + (BPC+1)'(carry_q);
        dig_ext  = WIDTH'(digit[BPC-1:0]);
        sum_next = (sum_sr_q >> BPC) | (dig_ext << (WIDTH - BPC));
        last_dig = (cnt_q == CW'(NDIG - 1));
    end

    // Sum/CO only move on the final digit, so an abandoned add never leaks out.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            aval_q   <= '0;
            bval_q   <= '0;
            a_work_q <= '0;
            b_work_q <= '0;
            sum_sr_q <= '0;
            sum_q    <= '0;
            co_q     <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (loadb_press) bval_q <= SW;
                    if (run_press) begin
                        aval_q   <= SW;
                        a_work_q <= SW;
                        b_work_q <= loadb_press ? SW : bval_q;
                        sum_sr_q <= '0;
                        carry_q  <= 1'b0;
                        cnt_q    <= '0;
                    end
                end
                S_COMPUTE: begin
                    a_work_q <= a_work_q >> BPC;
                    b_work_q <= b_work_q >> BPC;
                    sum_sr_q <= sum_next;
                    carry_q  <= digit[BPC];
                    cnt_q    <= cnt_q + CW'(1);
                    if (last_dig) begin
                        sum_q <= sum_next;
                        co_q  <= digit[BPC];
                    end
                end
                default: ;
            endcase
        end
    end

    assign Sum  = sum_q;
    assign CO   = co_q;
    assign Aval = aval_q;
    assign Bval = bval_q;

endmodule
